// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
// Holds the FSM state encoding and the max-minutes BCD helper.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int SEC_PER_MIN    = 60;
    localparam int MAX_BCD_DIGITS = 8;

    // All-nines BCD vector for the given number of minute digits, LSB digit first.
    function automatic logic [4*MAX_BCD_DIGITS-1:0] max_minutes_bcd(input int digits);
        logic [4*MAX_BCD_DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_BCD_DIGITS; i++) begin
            if (i < digits) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/countdown_timer_bcd_dec.sv
// Single BCD digit decrementer: wraps 0 to max_val and raises borrow_out.
// Purely combinational; the digit passes through unchanged when dec_en is low.
module bcd_digit_dec (
    input  logic [3:0] digit,
    input  logic       dec_en,
    input  logic [3:0] max_val,
    output logic [3:0] next_digit,
    output logic       borrow_out
);

    always_comb begin
        next_digit = digit;
        borrow_out = 1'b0;
        if (dec_en) begin
            if (digit == 4'd0) begin
                next_digit = max_val;
                borrow_out = 1'b1;
            end else begin
                next_digit = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/countdown_timer_bcd.sv
// Countdown timer: binary seconds load, iterative conversion to BCD mm:ss,
// per-second BCD countdown and a blinking completion flag.
module countdown_timer_bcd
    import countdown_timer_pkg::*;
#(
    parameter int TIME_W     = 12,
    parameter int MIN_DIGITS = 2,
    parameter int CLK_DIV    = 50000000,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [TIME_W-1:0]       load_val,
    input  logic                    start,
    input  logic                    pause,
    output logic [3:0]              sec0,
    output logic [3:0]              sec1,
    output logic [4*MIN_DIGITS-1:0] min_bcd,
    output logic                    busy,
    output logic                    running,
    output logic                    done,
    output logic                    blink,
    output logic                    sat
);

    localparam int PW = (CLK_DIV   > 1) ? $clog2(CLK_DIV)   : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
    localparam logic [4*MAX_BCD_DIGITS-1:0] MAX_MIN_W = max_minutes_bcd(MIN_DIGITS);
    localparam logic [4*MIN_DIGITS-1:0] MAX_MIN = MAX_MIN_W[4*MIN_DIGITS-1:0];
    localparam logic [TIME_W-1:0] SIXTY = TIME_W'(SEC_PER_MIN);

    state_t            state_q, state_n;
    logic [TIME_W-1:0] work_q, work_n;
    logic [PW-1:0]     presc_q, presc_n;
    logic [BW-1:0]     bcnt_q, bcnt_n;
    logic [3:0]        s0_n, s1_n;
    logic [4*MIN_DIGITS-1:0] m_n, min_inc;
    logic              sat_n, blink_n;
    logic              inc_carry;

    logic              tick;
    logic              digits_zero;
    logic              dec_zero;
    logic [3:0]        dec_s0, dec_s1;
    logic              bor_s0, bor_s1;
    logic [4*MIN_DIGITS-1:0] dec_m;
    logic [MIN_DIGITS:0]     borrow_m;
    logic              borrow_unused;

    // A tick is swallowed by load or pause in the same cycle.
    assign tick = (state_q == RUN) && (presc_q == PRESC_MAX) && !load && !pause;
    assign digits_zero = (sec0 == 4'd0) && (sec1 == 4'd0) && (min_bcd == '0);

    bcd_digit_dec u_sec0 (
        .digit      (sec0),
        .dec_en     (tick),
        .max_val    (4'd9),
        .next_digit (dec_s0),
        .borrow_out (bor_s0)
    );

    bcd_digit_dec u_sec1 (
        .digit      (sec1),
        .dec_en     (bor_s0),
        .max_val    (4'd5),
        .next_digit (dec_s1),
        .borrow_out (bor_s1)
    );

    assign borrow_m[0] = bor_s1;

    for (genvar gi = 0; gi < MIN_DIGITS; gi++) begin : g_min_dec
        bcd_digit_dec u_min (
            .digit      (min_bcd[4*gi +: 4]),
            .dec_en     (borrow_m[gi]),
            .max_val    (4'd9),
            .next_digit (dec_m[4*gi +: 4]),
            .borrow_out (borrow_m[gi+1])
        );
    end

    // Top-digit borrow cannot occur: RUN leaves at 0:00 before any underflow.
    assign borrow_unused = borrow_m[MIN_DIGITS];
    assign dec_zero = (dec_s0 == 4'd0) && (dec_s1 == 4'd0) && (dec_m == '0);

    always_comb begin
        min_inc   = min_bcd;
        inc_carry = 1'b1;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (inc_carry) begin
                if (min_bcd[4*i +: 4] == 4'd9) begin
                    min_inc[4*i +: 4] = 4'd0;
                end else begin
                    min_inc[4*i +: 4] = min_bcd[4*i +: 4] + 4'd1;
                    inc_carry         = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_n = state_q;
        work_n  = work_q;
        presc_n = presc_q;
        bcnt_n  = bcnt_q;
        s0_n    = sec0;
        s1_n    = sec1;
        m_n     = min_bcd;
        sat_n   = sat;
        blink_n = blink;
        if (load) begin
            state_n = CONV;
            work_n  = load_val;
            presc_n = '0;
            bcnt_n  = '0;
            s0_n    = 4'd0;
            s1_n    = 4'd0;
            m_n     = '0;
            sat_n   = 1'b0;
            blink_n = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!pause && start) begin
                        if (digits_zero) begin
                            state_n = DONE;
                            blink_n = 1'b1;
                            bcnt_n  = '0;
                        end else begin
                            state_n = RUN;
                            presc_n = '0;
                        end
                    end
                end
                CONV: begin
                    if (work_q >= SIXTY) begin
                        if (min_bcd == MAX_MIN) begin
                            s1_n    = 4'd5;
                            s0_n    = 4'd9;
                            sat_n   = 1'b1;
                            state_n = IDLE;
                        end else begin
                            work_n = work_q - SIXTY;
                            m_n    = min_inc;
                        end
                    end else begin
                        // work < 60 here, so the low six bits hold the whole value.
                        s1_n    = 4'(work_q[5:0] / 6'd10);
                        s0_n    = 4'(work_q[5:0] % 6'd10);
                        state_n = IDLE;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_n = IDLE;
                        presc_n = '0;
                    end else begin
                        presc_n = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
                        if (tick) begin
                            s0_n = dec_s0;
                            s1_n = dec_s1;
                            m_n  = dec_m;
                            if (dec_zero) begin
                                state_n = DONE;
                                blink_n = 1'b1;
                                bcnt_n  = '0;
                            end
                        end
                    end
                end
                DONE: begin
                    if (bcnt_q == BLINK_MAX) begin
                        bcnt_n  = '0;
                        blink_n = ~blink;
                    end else begin
                        bcnt_n = bcnt_q + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            presc_q <= '0;
            bcnt_q  <= '0;
            sec0    <= 4'd0;
            sec1    <= 4'd0;
            min_bcd <= '0;
            sat     <= 1'b0;
            blink   <= 1'b0;
            busy    <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_n;
            work_q  <= work_n;
            presc_q <= presc_n;
            bcnt_q  <= bcnt_n;
            sec0    <= s0_n;
            sec1    <= s1_n;
            min_bcd <= m_n;
            sat     <= sat_n;
            blink   <= blink_n;
            busy    <= (state_n == CONV);
            running <= (state_n == RUN);
            done    <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Directed bench for countdown_timer_bcd with short dividers; a second
// instance with one minute digit shares the stimulus to exercise saturation.
module tb_countdown_timer_bcd;

    logic        clk;
    logic        rst;
    logic        load;
    logic [11:0] load_val;
    logic        start;
    logic        pause;

    logic [3:0]  sec0, sec1;
    logic [7:0]  min_bcd;
    logic        busy, running, done, blink, sat;

    logic [3:0]  sec0_1, sec1_1;
    logic [3:0]  min_bcd_1;
    logic        busy_1, running_1, done_1, blink_1, sat_1;

    int checks = 0;
    int errors = 0;
    int conv_cycles;

    countdown_timer_bcd #(
        .TIME_W(12), .MIN_DIGITS(2), .CLK_DIV(4), .BLINK_DIV(2)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val),
        .start(start), .pause(pause),
        .sec0(sec0), .sec1(sec1), .min_bcd(min_bcd),
        .busy(busy), .running(running), .done(done), .blink(blink), .sat(sat)
    );

    countdown_timer_bcd #(
        .TIME_W(12), .MIN_DIGITS(1), .CLK_DIV(4), .BLINK_DIV(2)
    ) dut1 (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val),
        .start(start), .pause(pause),
        .sec0(sec0_1), .sec1(sec1_1), .min_bcd(min_bcd_1),
        .busy(busy_1), .running(running_1), .done(done_1), .blink(blink_1), .sat(sat_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_load(input logic [11:0] v);
        load_val = v;
        load     = 1'b1;
        cyc(1);
        load     = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic pulse_pause();
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
    endtask

    // Counts cycles busy stays high after the load edge, bounded.
    task automatic wait_conv(input string tag);
        conv_cycles = 1;
        while (busy && conv_cycles < 300) begin
            cyc(1);
            if (busy) conv_cycles++;
        end
        chk({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
    endtask

    function automatic logic [31:0] digits();
        return {16'd0, min_bcd, sec1, sec0};
    endfunction

    function automatic logic [31:0] flags();
        return {27'd0, busy, running, done, blink, sat};
    endfunction

    initial begin
        rst = 1'b1; load = 1'b0; load_val = '0; start = 1'b0; pause = 1'b0;
        cyc(2);
        rst = 1'b0;
        chk("reset_digits", digits(), 32'h0000);
        chk("reset_flags", flags(), 32'h00);
        chk("reset_flags_1", {27'd0, busy_1, running_1, done_1, blink_1, sat_1}, 32'h00);

        // 125 s -> 02:05 after 3 busy cycles
        do_load(12'd125);
        chk("t1_busy_on", {31'd0, busy}, 32'd1);
        wait_conv("t1");
        chk("t1_latency", conv_cycles, 32'd3);
        chk("t1_digits", digits(), 32'h0205);
        chk("t1_flags", flags(), 32'h00);

        // 4095 s -> 68:15 in 69 cycles; one-digit instance saturates at 9:59
        do_load(12'd4095);
        wait_conv("t2");
        chk("t2_latency", conv_cycles, 32'd69);
        chk("t2_digits", digits(), 32'h6815);
        chk("t2_sat", {31'd0, sat}, 32'd0);
        chk("t2_digits_1", {20'd0, min_bcd_1, sec1_1, sec0_1}, 32'h959);
        chk("t2_sat_1", {31'd0, sat_1}, 32'd1);
        chk("t2_busy_1", {31'd0, busy_1}, 32'd0);

        // 61 s: 1:01 -> 1:00 -> 0:59 with minute borrow
        do_load(12'd61);
        wait_conv("t3");
        chk("t3_digits", digits(), 32'h0101);
        pulse_start();
        chk("t3_running", {31'd0, running}, 32'd1);
        cyc(3);
        chk("t3_before_tick", digits(), 32'h0101);
        cyc(1);
        chk("t3_first_tick", digits(), 32'h0100);
        cyc(4);
        chk("t3_min_borrow", digits(), 32'h0059);
        pulse_pause();
        chk("t3_paused", {31'd0, running}, 32'd0);

        // 2 s: countdown to DONE, blink 1,1,0,0,1; start/pause ignored in DONE
        do_load(12'd2);
        wait_conv("t4");
        chk("t4_digits", digits(), 32'h0002);
        pulse_start();
        cyc(4);
        chk("t4_one", digits(), 32'h0001);
        cyc(4);
        chk("t4_zero", digits(), 32'h0000);
        chk("t4_done_flags", flags(), 32'h06);
        pulse_start();
        chk("t4_blink1", flags(), 32'h06);
        pulse_pause();
        chk("t4_blink2", flags(), 32'h04);
        cyc(1);
        chk("t4_blink3", flags(), 32'h04);
        cyc(1);
        chk("t4_blink4", flags(), 32'h06);
        chk("t4_digits_hold", digits(), 32'h0000);

        // 0:10: pause mid-second, resume, then pause on a tick cycle
        do_load(12'd10);
        chk("t5_flags_after_load", flags(), 32'h10);
        wait_conv("t5");
        chk("t5_digits", digits(), 32'h0010);
        pulse_start();
        cyc(2);
        pulse_pause();
        chk("t5_paused", {31'd0, running}, 32'd0);
        cyc(10);
        chk("t5_frozen", digits(), 32'h0010);
        pulse_start();
        cyc(3);
        chk("t5_resume_hold", digits(), 32'h0010);
        cyc(1);
        chk("t5_resume_tick", digits(), 32'h0009);
        cyc(3);
        pulse_pause();
        chk("t5_tick_suppressed", digits(), 32'h0009);
        chk("t5_idle", flags(), 32'h00);

        // reset mid-conversion, then load+start in the same cycle
        do_load(12'd4095);
        cyc(5);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("t6_rst_digits", digits(), 32'h0000);
        chk("t6_rst_flags", flags(), 32'h00);
        chk("t6_rst_sat_1", {31'd0, sat_1}, 32'd0);
        load_val = 12'd5;
        load     = 1'b1;
        start    = 1'b1;
        cyc(1);
        load     = 1'b0;
        start    = 1'b0;
        chk("t6_load_start_flags", flags(), 32'h10);
        cyc(1);
        chk("t6_conv_result", digits(), 32'h0005);
        chk("t6_not_running", flags(), 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
